// File: rtl/buffer_if_id_if.sv
// Word bus between pipeline stages: instruction, PC+4 and a valid/ready handshake.
// The master drives the word and valid; the slave answers with ready.
interface buffer_if_id_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] instruction;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic                  valid;
   logic                  ready;

   modport master (output instruction, output pc_plus4, output valid, input ready);
   modport slave  (input instruction, input pc_plus4, input valid, output ready);
endinterface

// File: rtl/buffer_if_id.sv
// IF/ID pipeline register with a 2-entry skid buffer, flush-to-NOP and a
// saturating counter of cycles where fetch was held off.
module buffer_if_id #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   buffer_if_id_if.slave        fetch_if,
   buffer_if_id_if.master       dec_if,
   input  logic                 i_flush,
   output logic [CNT_WIDTH-1:0] o_stall_count
);
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
   logic [ADDR_WIDTH-1:0] main_pc_q, main_pc_d;
   logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;

   logic ready_int;
   logic valid_int;
   logic in_xfer;
   logic out_xfer;

   // Ready comes from registered state only, so decode back-pressure never
   // forms a combinational path into the fetch stage.
   assign ready_int = (state_q != FULL);
   assign valid_int = (state_q != EMPTY);
   assign in_xfer   = fetch_if.valid && ready_int;
   assign out_xfer  = valid_int && dec_if.ready;

   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      stall_d      = stall_q;

      unique case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_instr_d = fetch_if.instruction;
               main_pc_d    = fetch_if.pc_plus4;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (in_xfer && out_xfer) begin
               main_instr_d = fetch_if.instruction;
               main_pc_d    = fetch_if.pc_plus4;
            end else if (in_xfer) begin
               skid_instr_d = fetch_if.instruction;
               skid_pc_d    = fetch_if.pc_plus4;
               state_d      = FULL;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               main_instr_d = skid_instr_q;
               main_pc_d    = skid_pc_q;
               state_d      = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase

      // A redirect kills everything held, including a word arriving this edge.
      if (i_flush) begin
         state_d      = EMPTY;
         main_instr_d = '0;
         main_pc_d    = '0;
         skid_instr_d = '0;
         skid_pc_d    = '0;
      end

      if (fetch_if.valid && !ready_int && (stall_q != {CNT_WIDTH{1'b1}}))
         stall_d = stall_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EMPTY;
         main_instr_q <= '0;
         main_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         stall_q      <= stall_d;
      end
   end

   // An empty buffer presents an all-zero word, which decodes as sll $0,$0,0.
   assign fetch_if.ready     = ready_int;
   assign dec_if.valid       = valid_int;
   assign dec_if.instruction = valid_int ? main_instr_q : '0;
   assign dec_if.pc_plus4    = valid_int ? main_pc_q : '0;
   assign o_stall_count      = stall_q;
endmodule
